// File: rtl/stopwatch_core_if.sv
// Control and display signal bundle between a stopwatch front panel and stopwatch_core.
interface stopwatch_core_if;
  logic        run_md;
  logic        disp_md;
  logic        clr_on;
  logic [15:0] disp_data;
  logic        tick_cs;
  logic        ovf;

  modport master (
    output run_md,
    output disp_md,
    output clr_on,
    input  disp_data,
    input  tick_cs,
    input  ovf
  );

  modport slave (
    input  run_md,
    input  disp_md,
    input  clr_on,
    output disp_data,
    output tick_cs,
    output ovf
  );
endinterface

// File: rtl/stopwatch_core.sv
// Centisecond stopwatch: prescaler, rippling BCD time-of-day counter (hh:mm:ss.cc),
// clear gating and a registered two-page 4-digit display.
module stopwatch_core #(
  parameter int DIV = 1000000
) (
  input  logic           clk,
  input  logic           rst,
  stopwatch_core_if.slave sw
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  // {carry_out, next_digit}: advance one BCD digit that wraps to 0 after lim
  function automatic logic [4:0] bcd_step(input logic [3:0] digit,
                                          input logic [3:0] lim,
                                          input logic       cin);
    logic [4:0] res;
    if (!cin) begin
      res = {1'b0, digit};
    end else if (digit >= lim) begin
      res = {1'b1, 4'd0};
    end else begin
      res = {1'b0, digit + 4'd1};
    end
    return res;
  endfunction

  logic [PW-1:0] presc_r;
  logic [31:0]   time_r;      // {hr_t, hr_u, min_t, min_u, sec_t, sec_u, cs_t, cs_u}
  logic [31:0]   time_nxt_s;
  logic [15:0]   disp_r;
  logic          tick_r;
  logic          ovf_r;
  logic          clear_s;
  logic          tick_s;
  logic          wrap_s;
  logic [3:0]    hr_u_lim_s;
  logic [4:0]    cu_s, ct_s, su_s, st_s, mu_s, mt_s, hu_s, ht_s;

  assign clear_s = sw.clr_on & ~sw.run_md;
  assign tick_s  = sw.run_md & ~clear_s & (presc_r == PRESC_MAX);

  // Hours units wrap at 3 once the tens digit reaches 2, giving 23 -> 00
  assign hr_u_lim_s = (time_r[31:28] >= 4'd2) ? 4'd3 : 4'd9;

  assign cu_s = bcd_step(time_r[3:0],   4'd9,       1'b1);
  assign ct_s = bcd_step(time_r[7:4],   4'd9,       cu_s[4]);
  assign su_s = bcd_step(time_r[11:8],  4'd9,       ct_s[4]);
  assign st_s = bcd_step(time_r[15:12], 4'd5,       su_s[4]);
  assign mu_s = bcd_step(time_r[19:16], 4'd9,       st_s[4]);
  assign mt_s = bcd_step(time_r[23:20], 4'd5,       mu_s[4]);
  assign hu_s = bcd_step(time_r[27:24], hr_u_lim_s, mt_s[4]);
  assign ht_s = bcd_step(time_r[31:28], 4'd2,       hu_s[4]);

  assign time_nxt_s = {ht_s[3:0], hu_s[3:0], mt_s[3:0], mu_s[3:0],
                       st_s[3:0], su_s[3:0], ct_s[3:0], cu_s[3:0]};
  assign wrap_s     = ht_s[4];

  // Prescaler: counts while running, holds while paused, zeroed by clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_r <= '0;
    end else if (clear_s) begin
      presc_r <= '0;
    end else if (sw.run_md) begin
      if (presc_r == PRESC_MAX) begin
        presc_r <= '0;
      end else begin
        presc_r <= presc_r + PW'(1);
      end
    end else begin
      presc_r <= presc_r;
    end
  end

  // Time digits: the whole carry chain resolves in one tick cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      time_r <= 32'd0;
    end else if (clear_s) begin
      time_r <= 32'd0;
    end else if (tick_s) begin
      time_r <= time_nxt_s;
    end else begin
      time_r <= time_r;
    end
  end

  // Tick and overflow pulses line up with the cycle showing the new time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      tick_r <= tick_s;
      ovf_r  <= tick_s & wrap_s;
    end
  end

  // Display page register, one cycle behind the time digits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_r <= 16'd0;
    end else if (sw.disp_md) begin
      disp_r <= time_r[31:16];
    end else begin
      disp_r <= time_r[15:0];
    end
  end

  assign sw.disp_data = disp_r;
  assign sw.tick_cs   = tick_r;
  assign sw.ovf       = ovf_r;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed self-checking bench for stopwatch_core with DIV=4 (one tick every 4 clk).
module tb_stopwatch_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] preload_val;
  int          n_checks = 0;
  int          n_pass   = 0;

  stopwatch_core_if sw_if ();

  stopwatch_core #(.DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_time();
    sw_if.run_md = 1'b0;
    sw_if.clr_on = 1'b1;
    step(1);
    sw_if.clr_on = 1'b0;
    step(1);
  endtask

  // Shortcut to deep time values; the hold path latches the forced digits
  task automatic preload();
    sw_if.run_md = 1'b0;
    force dut.time_r = preload_val;
    step(1);
    release dut.time_r;
    step(1);
  endtask

  initial begin
    int ticks;
    int bad;
    int first;

    rst           = 1'b0;
    sw_if.run_md  = 1'b0;
    sw_if.disp_md = 1'b0;
    sw_if.clr_on  = 1'b0;
    preload_val   = 32'd0;
    step(3);
    check("rst_disp", 32'(sw_if.disp_data), 32'h0);
    check("rst_tick", 32'(sw_if.tick_cs), 32'h0);
    check("rst_ovf",  32'(sw_if.ovf), 32'h0);

    // Basic count: 40 clk -> 10 ticks on every 4th edge
    rst          = 1'b1;
    sw_if.run_md = 1'b1;
    ticks = 0;
    bad   = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (sw_if.tick_cs) begin
        ticks++;
        if (k % 4 != 0) bad++;
      end
    end
    check("basic_ticks",   32'(ticks), 32'd10);
    check("basic_spacing", 32'(bad), 32'd0);
    step(1);
    check("basic_disp", 32'(sw_if.disp_data), 32'h0010);

    // Pause / resume keeps the partial interval
    clear_time();
    check("clear_to_zero", 32'(sw_if.disp_data), 32'h0000);
    sw_if.run_md = 1'b1;
    ticks = 0;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      if (sw_if.tick_cs) ticks++;
    end
    check("pause_first_tick", 32'(ticks), 32'd1);
    sw_if.run_md = 1'b0;
    ticks = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (sw_if.tick_cs) ticks++;
    end
    check("pause_hold", 32'(ticks), 32'd0);
    sw_if.run_md = 1'b1;
    step(1);
    check("resume_early", 32'(sw_if.tick_cs), 32'h0);
    step(1);
    check("resume_tick", 32'(sw_if.tick_cs), 32'h1);
    step(1);
    check("resume_cs", 32'(sw_if.disp_data), 32'h0002);

    // Cascade: long run to 00:00:59.99 then one more tick
    clear_time();
    sw_if.run_md = 1'b1;
    step(23996);
    sw_if.run_md = 1'b0;
    step(1);
    check("cascade_pre", 32'(sw_if.disp_data), 32'h5999);
    sw_if.run_md = 1'b1;
    step(3);
    check("cascade_early", 32'(sw_if.tick_cs), 32'h0);
    step(1);
    check("cascade_tick",   32'(sw_if.tick_cs), 32'h1);
    check("cascade_no_ovf", 32'(sw_if.ovf), 32'h0);
    sw_if.run_md = 1'b0;
    step(1);
    check("cascade_sec_page", 32'(sw_if.disp_data), 32'h0000);
    sw_if.disp_md = 1'b1;
    step(1);
    check("cascade_min_page", 32'(sw_if.disp_data), 32'h0001);
    sw_if.disp_md = 1'b0;
    step(1);
    check("page_back", 32'(sw_if.disp_data), 32'h0000);

    // Hour tens carry 19:59:59.99 -> 20:00:00.00
    preload_val = 32'h1959_5999;
    preload();
    sw_if.run_md = 1'b1;
    step(4);
    check("hour_tick",   32'(sw_if.tick_cs), 32'h1);
    check("hour_no_ovf", 32'(sw_if.ovf), 32'h0);
    sw_if.run_md  = 1'b0;
    sw_if.disp_md = 1'b1;
    step(1);
    check("hour_page", 32'(sw_if.disp_data), 32'h2000);

    // Day overflow 23:59:59.99 -> 00:00:00.00
    sw_if.disp_md = 1'b0;
    preload_val = 32'h2359_5999;
    preload();
    check("ovf_pre", 32'(sw_if.disp_data), 32'h5999);
    sw_if.run_md = 1'b1;
    step(3);
    check("ovf_early", 32'(sw_if.ovf), 32'h0);
    step(1);
    check("ovf_pulse", 32'(sw_if.ovf), 32'h1);
    check("ovf_tick",  32'(sw_if.tick_cs), 32'h1);
    sw_if.run_md = 1'b0;
    step(1);
    check("ovf_single",   32'(sw_if.ovf), 32'h0);
    check("ovf_sec_page", 32'(sw_if.disp_data), 32'h0000);
    sw_if.disp_md = 1'b1;
    step(1);
    check("ovf_hr_page", 32'(sw_if.disp_data), 32'h0000);

    // Clear is ignored while running, honoured while stopped
    sw_if.disp_md = 1'b0;
    preload_val = 32'h0000_1234;
    preload();
    sw_if.run_md = 1'b1;
    sw_if.clr_on = 1'b1;
    step(1);
    sw_if.clr_on = 1'b0;
    check("gate_no_clear", 32'(sw_if.disp_data), 32'h1234);
    step(2);
    check("gate_early", 32'(sw_if.tick_cs), 32'h0);
    step(1);
    check("gate_tick", 32'(sw_if.tick_cs), 32'h1);
    sw_if.run_md = 1'b0;
    step(1);
    check("gate_run_disp", 32'(sw_if.disp_data), 32'h1235);
    sw_if.clr_on = 1'b1;
    step(1);
    check("clear_tick", 32'(sw_if.tick_cs), 32'h0);
    check("clear_lag",  32'(sw_if.disp_data), 32'h1235);
    sw_if.clr_on = 1'b0;
    step(1);
    check("clear_disp", 32'(sw_if.disp_data), 32'h0000);

    // Asynchronous reset between clock edges
    preload();
    sw_if.run_md = 1'b1;
    step(2);
    #3;
    rst = 1'b0;
    #1;
    check("arst_disp", 32'(sw_if.disp_data), 32'h0);
    check("arst_tick", 32'(sw_if.tick_cs), 32'h0);
    check("arst_ovf",  32'(sw_if.ovf), 32'h0);
    #2;
    rst = 1'b1;
    first = 0;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      if (sw_if.tick_cs && first == 0) first = k;
    end
    check("arst_first_tick", 32'(first), 32'd4);
    sw_if.run_md = 1'b0;
    step(1);
    check("arst_cs", 32'(sw_if.disp_data), 32'h0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 The block SHALL have parameter DIV, default 1000000, meaning clk cycles per centisecond tick (minimum 2).
REQ-002 clk  input  1  100 MHz system clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 run_md  input  1  run mode level: 1 = counting, 0 = stopped.
REQ-005 disp_md  input  1  display select level: 0 = sec.centisec page, 1 = hour:min page.
REQ-006 clr_on  input  1  clear request level, held high for as long as the button is pressed.
REQ-007 disp_data  output  16  four BCD digits, [15:12] leftmost to [3:0] rightmost, registered.
REQ-008 tick_cs  output  1  one-cycle pulse on each centisecond advance.
REQ-009 ovf  output  1  one-cycle pulse when time wraps 23:59:59.99 -> 00:00:00.00.

Function
REQ-010 Prescaler SHALL be a counter 0..DIV-1 that increments once per clk while run_md=1 and clear is inactive.
REQ-011 When the prescaler is at DIV-1 and increments, it SHALL return to 0 and raise tick_cs for exactly that following cycle.
REQ-012 While run_md=0, the prescaler SHALL hold its value, so a paused partial interval resumes without loss.
REQ-013 Time SHALL be held as BCD digits: cs 00-99, sec 00-59, min 00-59, hr 00-23; each digit 4 bits, never outside 0-9.
REQ-014 On each tick, cs SHALL increment; 99 SHALL wrap to 00 with a carry into sec; sec 59 SHALL wrap to 00 with a carry into min; min 59 SHALL wrap to 00 with a carry into hr; hr 23 SHALL wrap to 00.
REQ-015 All carries SHALL ripple within the same tick cycle, so no intermediate value such as 00:00:59.100 is ever visible.
REQ-016 ovf SHALL pulse high for exactly the cycle in which the full 23:59:59.99 -> 00:00:00.00 wrap occurs, coincident with tick_cs.
REQ-017 Clear is active when clr_on=1 and run_md=0.
REQ-018 While clear is active, the prescaler and all time digits SHALL be forced to 0 synchronously, and tick_cs and ovf SHALL stay 0.
REQ-019 When clr_on=1 and run_md=1, clr_on SHALL be ignored and counting SHALL continue.
REQ-020 If a tick and an active clear coincide, clear SHALL win and no tick_cs or ovf pulse SHALL be emitted.
REQ-021 disp_data SHALL be registered one cycle after the selected time values.
- disp_md=0: disp_data = {sec_t, sec_u, cs_t, cs_u}.
- disp_md=1: disp_data = {hr_t, hr_u, min_t, min_u}.
REQ-022 A disp_md change SHALL affect only disp_data, one cycle later, and SHALL never disturb the counters.
REQ-023 A run_md change SHALL take effect on the next clk edge; no edge detection is applied, because inputs are already-registered levels.

Reset
REQ-024 While rst=0, prescaler, all time digits, disp_data, tick_cs and ovf SHALL be 0 regardless of clk.
REQ-025 Assertion of rst mid-count SHALL clear all state immediately.
REQ-026 After rst deasserts, counting SHALL begin from 00:00:00.00 with prescaler 0 on the first clk where run_md=1.

Verification (DIV=4 for simulation)
REQ-027 Basic count: rst release, run_md=1 for 40 clk -> 10 tick_cs pulses, one every 4 clk; disp_md=0 gives disp_data=16'h0010 after the tenth tick plus one cycle.
REQ-028 Pause/resume: run_md=1 for 6 clk, then 0 for 20 clk, then 1 -> the second tick arrives 2 clk after resume, and cs=02 after that tick.
REQ-029 Cascade: preload via a long run to 00:00:59.99, then one tick -> disp_md=0 shows 16'h0000 and disp_md=1 shows 16'h0001 (min=01).
REQ-030 Overflow: run through 23:59:59.99 -> the next tick gives ovf=1 for 1 cycle with tick_cs=1, and all digits are 0.
REQ-031 Clear gating: at time 00:00:12.34 with run_md=1, pulse clr_on -> no change. Then set run_md=0 and pulse clr_on -> digits are 0 the next cycle and disp_data=16'h0000 one cycle later.
REQ-032 Async reset: drop rst mid-interval, between clk edges -> all outputs are 0 immediately; the first tick after release arrives 4 clk after run_md=1.
